// File: rtl/bcd_sub_serial.sv
// Serial packed-BCD subtractor: one digit per cycle, least significant digit first.
// Invalid digits are flagged at latch time, and the result is forced to zero at the end.
module bcd_sub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                bin,
  output logic [4*DIGITS-1:0] diff,
  output logic                bout,
  output logic                busy,
  output logic                done,
  output logic                invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SUB  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          borrow;

  logic [3:0] ad;
  logic [3:0] bd;
  logic [4:0] t;
  logic [3:0] dd;
  logic       nb;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    has_bad_digit = 1'b0;
    for (int unsigned i = 0; i < unsigned'(DIGITS); i++) begin
      if (v[i*4 +: 4] > 4'd9) has_bad_digit = 1'b1;
    end
  endfunction

  // 5-bit difference: the top bit is the sign, i.e. the borrow out of this digit
  always_comb begin
    ad = a_q[idx*4 +: 4];
    bd = b_q[idx*4 +: 4];
    t  = {1'b0, ad} - {1'b0, bd} - {4'b0, borrow};
    nb = t[4];
    dd = nb ? (t[3:0] + 4'd10) : t[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      borrow  <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      invalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            borrow  <= bin;
            diff    <= '0;
            bout    <= 1'b0;
            invalid <= has_bad_digit(a) | has_bad_digit(b);
            idx     <= '0;
            busy    <= 1'b1;
            state   <= SUB;
          end
        end
        SUB: begin
          diff[idx*4 +: 4] <= dd;
          borrow           <= nb;
          idx              <= idx + 1'b1;
          if (idx == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
            // Later assignment overrides the digit write above for bad operands
            if (invalid) begin
              diff <= '0;
              bout <= 1'b0;
            end else begin
              bout <= nb;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
